// File: rtl/rdwr_responder_if.sv
// rdwr_responder_if
//
// Bundles every non-clock signal around rdwr_responder: the multiplexed
// command bus from custom_master_slave, the Avalon-MM master port toward the
// memory interconnect, and the status outputs.
//
// Modports:
//   slave  - the responder itself: consumes commands and Avalon responses,
//            drives the Avalon request and the status signals.
//   master - the surrounding environment (command source plus memory side):
//            drives commands and Avalon responses, observes everything else.
//
// Signals:
//   rdwr_cntl          1 = read, 0 = write (address phase only)
//   n_action           active-low command strobe, one phase per low cycle
//   add_data_sel       0 = rdwr_address carries address, 1 = write data
//   rdwr_address       multiplexed address/data bus
//   master_address     Avalon address (ADDR_W bits)
//   master_read        Avalon read request
//   master_write       Avalon write request
//   master_writedata   Avalon write data
//   master_byteenable  Avalon byte enables (always all lanes)
//   master_readdata    Avalon read data
//   master_waitrequest Avalon stall
//   rd_data            last captured read data
//   done               one-cycle completion pulse
//   busy               responder not idle
//   protocol_err       one-cycle pulse on an ignored or illegal phase
interface rdwr_responder_if #(
  parameter int unsigned ADDR_W = 32
);
  // Command bus
  logic              rdwr_cntl;
  logic              n_action;
  logic              add_data_sel;
  logic [31:0]       rdwr_address;

  // Avalon-MM master port
  logic [ADDR_W-1:0] master_address;
  logic              master_read;
  logic              master_write;
  logic [31:0]       master_writedata;
  logic [3:0]        master_byteenable;
  logic [31:0]       master_readdata;
  logic              master_waitrequest;

  // Status
  logic [31:0]       rd_data;
  logic              done;
  logic              busy;
  logic              protocol_err;

  modport slave (
    input  rdwr_cntl,
    input  n_action,
    input  add_data_sel,
    input  rdwr_address,
    output master_address,
    output master_read,
    output master_write,
    output master_writedata,
    output master_byteenable,
    input  master_readdata,
    input  master_waitrequest,
    output rd_data,
    output done,
    output busy,
    output protocol_err
  );

  modport master (
    output rdwr_cntl,
    output n_action,
    output add_data_sel,
    output rdwr_address,
    input  master_address,
    input  master_read,
    input  master_write,
    input  master_writedata,
    input  master_byteenable,
    output master_readdata,
    output master_waitrequest,
    input  rd_data,
    input  done,
    input  busy,
    input  protocol_err
  );

endinterface

// File: rtl/rdwr_responder.sv
// rdwr_responder
//
// Decodes the multiplexed address/data command stream produced by
// custom_master_slave and executes one Avalon-MM read or write per command.
// The request is held until waitrequest releases; completion is reported with
// a one-cycle done pulse and read data is kept in rd_data until the next read
// completes. Commands are never queued: phases arriving while a transfer is
// in flight are dropped and flagged on protocol_err.
//
// Parameters:
//   ADDR_W          width of master_address (low bits of the latched address)
//   TIMEOUT_CYCLES  waitrequest stall limit, only with RDWR_TIMEOUT_EN
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous active-low reset
//   bus      rdwr_responder_if.slave: command bus, Avalon master, status
//
// Build option:
//   RDWR_TIMEOUT_EN  when defined, a request stalled for TIMEOUT_CYCLES
//                    consecutive waitrequest cycles is abandoned: protocol_err
//                    and done pulse, rd_data is left unchanged. When undefined
//                    the responder waits on waitrequest indefinitely.
//
// All outputs are registered; master_byteenable is constant all-lanes.
module rdwr_responder #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic            clk,
  input logic            reset_n,
  rdwr_responder_if.slave bus
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitData = 3'd1;
  localparam logic [2:0] StIssueWr  = 3'd2;
  localparam logic [2:0] StIssueRd  = 3'd3;
  localparam logic [2:0] StDone     = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              mread_q, mread_d;
  logic              mwrite_q, mwrite_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              perr_q, perr_d;
  logic              busy_q, busy_d;

  // Phase decode of the command strobe
  logic phase_vld;
  logic addr_phase;
  logic data_phase;

  assign phase_vld  = !bus.n_action;
  assign addr_phase = phase_vld && !bus.add_data_sel;
  assign data_phase = phase_vld && bus.add_data_sel;

`ifdef RDWR_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tmo_hit;

  // The current stall cycle is the TIMEOUT_CYCLES-th consecutive one
  assign tmo_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mread_d   = mread_q;
    mwrite_d  = mwrite_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    perr_d    = 1'b0;
`ifdef RDWR_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      StIdle, StWaitData: begin
        if (addr_phase) begin
          // A fresh address phase (also a re-issue while waiting for data)
          // replaces address and direction. Direction is carried by the state.
          addr_d = bus.rdwr_address[ADDR_W-1:0];
          if (bus.rdwr_cntl) begin
            state_d = StIssueRd;
            mread_d = 1'b1;
`ifdef RDWR_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d = StWaitData;
          end
        end else if (data_phase) begin
          if (state_q == StWaitData) begin
            wdata_d  = bus.rdwr_address;
            mwrite_d = 1'b1;
            state_d  = StIssueWr;
`ifdef RDWR_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end else begin
            // Data without a preceding address
            perr_d = 1'b1;
          end
        end
      end

      StIssueWr: begin
        perr_d = phase_vld;
        if (!bus.master_waitrequest) begin
          mwrite_d = 1'b0;
          done_d   = 1'b1;
          state_d  = StDone;
        end
`ifdef RDWR_TIMEOUT_EN
        else if (tmo_hit) begin
          mwrite_d = 1'b0;
          perr_d   = 1'b1;
          done_d   = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end

      StIssueRd: begin
        perr_d = phase_vld;
        if (!bus.master_waitrequest) begin
          rd_data_d = bus.master_readdata;
          mread_d   = 1'b0;
          done_d    = 1'b1;
          state_d   = StDone;
        end
`ifdef RDWR_TIMEOUT_EN
        else if (tmo_hit) begin
          // Abandoned read: rd_data keeps its previous value
          mread_d = 1'b0;
          perr_d  = 1'b1;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end

      StDone: begin
        // done is high during this cycle; nothing is accepted until IDLE
        perr_d  = phase_vld;
        state_d = StIdle;
      end

      default: begin
        state_d  = StIdle;
        mread_d  = 1'b0;
        mwrite_d = 1'b0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      mread_q   <= 1'b0;
      mwrite_q  <= 1'b0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef RDWR_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mread_q   <= mread_d;
      mwrite_q  <= mwrite_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      perr_q    <= perr_d;
      busy_q    <= busy_d;
`ifdef RDWR_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.master_address    = addr_q;
  assign bus.master_read       = mread_q;
  assign bus.master_write      = mwrite_q;
  assign bus.master_writedata  = wdata_q;
  assign bus.master_byteenable = 4'hF;
  assign bus.rd_data           = rd_data_q;
  assign bus.done              = done_q;
  assign bus.busy              = busy_q;
  assign bus.protocol_err      = perr_q;

endmodule

// File: tb/tb_rdwr_responder.sv
// tb_rdwr_responder
//
// Drives rdwr_responder through its interface and acts as the memory behind
// the Avalon port. Expectations come from a transaction-level view: a write
// of (addr, data) with s stalls keeps master_write up for s+1 cycles and then
// pulses done; a read returns the reference memory contents after s+1 request
// cycles; any phase outside IDLE/WAIT_DATA (or data in IDLE) flags
// protocol_err on the following cycle.
module tb_rdwr_responder;

  logic tb_clk = 1'b0;
  logic reset_n;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bit          exp_perr = 1'b0;
  logic [31:0] last_rd  = 32'h0;
  logic [31:0] mem [bit [31:0]];

  always #5 tb_clk = ~tb_clk;

  rdwr_responder_if #(.ADDR_W(32)) bus ();

  rdwr_responder #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk     (tb_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Strobe high; the remaining command lines carry junk that must be ignored
  task automatic drive_idle();
    bus.n_action     = 1'b1;
    bus.add_data_sel = 1'($urandom_range(0, 1));
    bus.rdwr_cntl    = 1'($urandom_range(0, 1));
    bus.rdwr_address = $urandom;
  endtask

  task automatic drive_cmd(input logic sel, input logic cntl, input logic [31:0] v);
    bus.n_action     = 1'b0;
    bus.add_data_sel = sel;
    bus.rdwr_cntl    = cntl;
    bus.rdwr_address = v;
  endtask

  // One clock; outputs sampled 1 time unit after the edge
  task automatic cycle();
    @(posedge tb_clk);
    #1;
    check("protocol_err", 32'(bus.protocol_err), 32'(exp_perr));
    check("rd_wr_exclusive", 32'(bus.master_read & bus.master_write), 32'h0);
    exp_perr = 1'b0;
    drive_idle();
  endtask

  // Cycle in DONE: done is high now and must drop next edge; a phase here is dropped
  task automatic finish_txn(input bit inj);
    bus.master_waitrequest = 1'($urandom_range(0, 1));
    if (inj && $urandom_range(0, 2) == 0) begin
      drive_cmd(1'b0, 1'b1, $urandom);
      exp_perr = 1'b1;
    end
    cycle();
    check("done_one_cycle", 32'(bus.done), 32'h0);
    check("idle_after_done", 32'(bus.busy), 32'h0);
    check("rd_data_hold", bus.rd_data, last_rd);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int stalls,
                          input int gap, input bit reissue, input logic [31:0] decoy,
                          input bit inj);
    if (reissue) begin
      drive_cmd(1'b0, 1'b0, decoy);
      cycle();
      check("wr_decoy_addr", bus.master_address, decoy);
      check("wr_decoy_busy", 32'(bus.busy), 32'h1);
    end
    drive_cmd(1'b0, 1'b0, addr);
    cycle();
    check("wr_addr", bus.master_address, addr);
    check("wr_busy", 32'(bus.busy), 32'h1);
    check("wr_not_yet", 32'(bus.master_write), 32'h0);
    for (int g = 0; g < gap; g++) begin
      cycle();
      check("wr_wait_data", 32'(bus.master_write), 32'h0);
      check("wr_wait_done", 32'(bus.done), 32'h0);
    end
    drive_cmd(1'b1, 1'($urandom_range(0, 1)), data);
    cycle();
    check("wr_req", 32'(bus.master_write), 32'h1);
    check("wr_data", bus.master_writedata, data);
    check("wr_addr_req", bus.master_address, addr);
    check("wr_byteen", 32'(bus.master_byteenable), 32'hF);
    for (int i = 0; i <= stalls; i++) begin
      bus.master_waitrequest = (i < stalls);
      if (inj && $urandom_range(0, 2) == 0) begin
        drive_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        exp_perr = 1'b1;
      end
      cycle();
      if (i < stalls) begin
        check("wr_stall_req", 32'(bus.master_write), 32'h1);
        check("wr_stall_done", 32'(bus.done), 32'h0);
        check("wr_stall_data", bus.master_writedata, data);
        check("wr_stall_addr", bus.master_address, addr);
      end else begin
        check("wr_end_req", 32'(bus.master_write), 32'h0);
        check("wr_done", 32'(bus.done), 32'h1);
        mem[addr] = data;
      end
    end
    finish_txn(inj);
  endtask

  task automatic do_read(input logic [31:0] addr, input int stalls, input bit inj);
    logic [31:0] exp;
    exp = mem_rd(addr);
    drive_cmd(1'b0, 1'b1, addr);
    cycle();
    check("rd_req", 32'(bus.master_read), 32'h1);
    check("rd_addr", bus.master_address, addr);
    check("rd_busy", 32'(bus.busy), 32'h1);
    for (int i = 0; i <= stalls; i++) begin
      bus.master_waitrequest = (i < stalls);
      bus.master_readdata    = (i < stalls) ? $urandom : exp;
      if (inj && $urandom_range(0, 2) == 0) begin
        drive_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        exp_perr = 1'b1;
      end
      cycle();
      if (i < stalls) begin
        check("rd_stall_req", 32'(bus.master_read), 32'h1);
        check("rd_stall_done", 32'(bus.done), 32'h0);
        check("rd_stall_hold", bus.rd_data, last_rd);
      end else begin
        check("rd_end_req", 32'(bus.master_read), 32'h0);
        check("rd_done", 32'(bus.done), 32'h1);
        check("rd_data", bus.rd_data, exp);
        last_rd = exp;
      end
    end
    bus.master_readdata = $urandom;
    finish_txn(inj);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n                = 1'b0;
    bus.master_waitrequest = 1'b0;
    bus.master_readdata    = 32'h0;
    drive_idle();

    // Reset state
    cycle();
    cycle();
    check("rst_read", 32'(bus.master_read), 32'h0);
    check("rst_write", 32'(bus.master_write), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_addr", bus.master_address, 32'h0);
    check("rst_wdata", bus.master_writedata, 32'h0);
    check("rst_rd_data", bus.rd_data, 32'h0);
    check("rst_byteen", 32'(bus.master_byteenable), 32'hF);
    reset_n = 1'b1;
    cycle();

    // Reset in the middle of a stalled read
    drive_cmd(1'b0, 1'b1, 32'h40);
    cycle();
    bus.master_waitrequest = 1'b1;
    cycle();
    cycle();
    check("rmw_read_held", 32'(bus.master_read), 32'h1);
    reset_n = 1'b0;
    cycle();
    check("rmw_read_off", 32'(bus.master_read), 32'h0);
    check("rmw_no_done", 32'(bus.done), 32'h0);
    check("rmw_busy", 32'(bus.busy), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rmw_after_done", 32'(bus.done), 32'h0);
      check("rmw_after_read", 32'(bus.master_read), 32'h0);
      check("rmw_after_busy", 32'(bus.busy), 32'h0);
    end
    bus.master_waitrequest = 1'b0;

    // Write without stall, then read with three stall cycles
    do_write(32'd584, 32'd22, 0, 0, 1'b0, 32'h0, 1'b0);
    mem[32'h10] = 32'hDEAD_BEEF;
    do_read(32'h10, 3, 1'b0);

    // Address re-issue before the data phase
    do_write(32'h200, 32'h55, 0, 1, 1'b1, 32'h100, 1'b0);
    do_read(32'h200, 0, 1'b0);
    do_read(32'h100, 0, 1'b0);

    // Data phase while idle is flagged and ignored
    drive_cmd(1'b1, 1'b0, 32'h1234);
    exp_perr = 1'b1;
    cycle();
    check("idle_data_busy", 32'(bus.busy), 32'h0);
    check("idle_data_write", 32'(bus.master_write), 32'h0);

    // Address phase during a read is flagged; the read completes normally
    mem[32'h30] = 32'hCAFE_F00D;
    drive_cmd(1'b0, 1'b1, 32'h30);
    cycle();
    bus.master_waitrequest = 1'b1;
    drive_cmd(1'b0, 1'b0, 32'h999);
    exp_perr = 1'b1;
    cycle();
    check("inj_read_held", 32'(bus.master_read), 32'h1);
    check("inj_addr_kept", bus.master_address, 32'h30);
    bus.master_waitrequest = 1'b0;
    bus.master_readdata    = 32'hCAFE_F00D;
    cycle();
    check("inj_rd_done", 32'(bus.done), 32'h1);
    check("inj_rd_data", bus.rd_data, 32'hCAFE_F00D);
    last_rd = 32'hCAFE_F00D;
    finish_txn(1'b0);

`ifdef RDWR_TIMEOUT_EN
    // Read with waitrequest stuck high is abandoned after 8 stall cycles
    drive_cmd(1'b0, 1'b1, 32'h77);
    cycle();
    bus.master_waitrequest = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.master_readdata = $urandom;
      if (i == 8) exp_perr = 1'b1;
      cycle();
      check("tmo_read", 32'(bus.master_read), (i < 8) ? 32'h1 : 32'h0);
      check("tmo_done", 32'(bus.done), (i < 8) ? 32'h0 : 32'h1);
      check("tmo_rd_data", bus.rd_data, last_rd);
    end
    finish_txn(1'b0);
    bus.master_waitrequest = 1'b0;
`endif

    // Randomized back-to-back traffic with occasional illegal phases
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                 1'($urandom_range(0, 3) == 0), {26'h0, 4'($urandom_range(0, 15)), 2'b00},
                 1'b1);
      end else begin
        do_read(a, $urandom_range(0, 3), 1'b1);
      end
      for (int g = 0; g < int'($urandom_range(0, 1)); g++) begin
        cycle();
        check("gap_idle", 32'(bus.busy), 32'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
